// File: rtl/rename_pkg.sv
// Shared types and helpers for the N-wide register-rename stage.
package rename_pkg;

  // Widest architectural / physical register index the lane structs carry.
  // Narrower configurations zero-extend into these fields.
  localparam int AW_MAX = 8;
  localparam int PW_MAX = 10;

  // Physical register permanently bound to architectural x0.
  localparam int P0 = 0;

  // Index width for the architectural register file.
  function automatic int calc_aw(input int arch_regs);
    return (arch_regs > 1) ? $clog2(arch_regs) : 1;
  endfunction

  // Index width for the physical register file.
  function automatic int calc_pw(input int phys_regs);
    return (phys_regs > 1) ? $clog2(phys_regs) : 1;
  endfunction

  // One decoded lane as it arrives from the decoders.
  typedef struct packed {
    logic [AW_MAX-1:0] rs1;
    logic [AW_MAX-1:0] rs2;
    logic [AW_MAX-1:0] rd;
    logic              rd_we;
  } lane_t;

  // One renamed lane as handed to issue/dispatch.
  typedef struct packed {
    logic [PW_MAX-1:0] prs1;
    logic [PW_MAX-1:0] prs2;
    logic [PW_MAX-1:0] prd;
    logic [PW_MAX-1:0] old_prd;
    logic              rd_we;
  } ren_lane_t;

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical registers: up to POP_W entries leave from
// the head per cycle, up to PUSH_W entries arrive at the tail per cycle.
module rename_freelist
  import rename_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int ARCH_REGS = 32,
  parameter int POP_W     = 2,
  parameter int PUSH_W    = 2,
  localparam int PW       = calc_pw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PW:0]          pop_cnt,
  output logic [POP_W*PW-1:0]  peek,
  input  logic [PUSH_W-1:0]    push_valid,
  input  logic [PUSH_W*PW-1:0] push_preg,
  output logic [PW:0]          count
);

  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   push_cnt;
  logic [PUSH_W-1:0] push_we;
  logic [PW-1:0] push_idx [PUSH_W];

  // Pointer advance modulo DEPTH; offsets never exceed DEPTH.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PW'(sum);
  endfunction

  // Expose the next POP_W candidates from the head in order.
  always_comb begin
    peek = '0;
    for (int k = 0; k < POP_W; k++) begin
      peek[k*PW +: PW] = mem[wrap_idx(head, k)];
    end
  end

  // Compact valid, non-zero retire slots into consecutive tail positions.
  always_comb begin
    int n;
    n = 0;
    push_we = '0;
    for (int s = 0; s < PUSH_W; s++) begin
      push_idx[s] = '0;
      if (push_valid[s] && (push_preg[s*PW +: PW] != '0)) begin
        push_we[s]  = 1'b1;
        push_idx[s] = wrap_idx(tail, n);
        n = n + 1;
      end
    end
    push_cnt = (PW+1)'(n);
  end

  // Storage, pointers and occupancy; reset preloads the unmapped registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= (k < DEPTH - ARCH_REGS) ? PW'(ARCH_REGS + k) : '0;
      end
      head  <= '0;
      tail  <= PW'(DEPTH - ARCH_REGS);
      count <= (PW+1)'(DEPTH - ARCH_REGS);
    end else begin
      for (int s = 0; s < PUSH_W; s++) begin
        if (push_we[s]) mem[push_idx[s]] <= push_preg[s*PW +: PW];
      end
      head  <= wrap_idx(head, int'(pop_cnt));
      tail  <= wrap_idx(tail, int'(push_cnt));
      count <= count - pop_cnt + push_cnt;
    end
  end

  // Underflow is prevented upstream; overflow would mean a register was freed twice.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (pop_cnt <= count);
      assert ((int'(count) - int'(pop_cnt) + int'(push_cnt)) <= DEPTH - 1);
    end
  end

endmodule

// File: rtl/rename_stage_n.sv
// N-wide register-rename stage: RAT lookup with intra-group bypass, free-list
// allocation, retire recycling and a registered valid/ready output.
module rename_stage_n
  import rename_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int ARCH_REGS    = 32,
  parameter int PHYS_REGS    = 64,
  parameter int RETIRE_WIDTH = 2,
  localparam int AW          = calc_aw(ARCH_REGS),
  localparam int PW          = calc_pw(PHYS_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*AW-1:0]        in_rs1,
  input  logic [WIDTH*AW-1:0]        in_rs2,
  input  logic [WIDTH*AW-1:0]        in_rd,
  input  logic [WIDTH-1:0]           in_rd_we,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*PW-1:0]        out_prs1,
  output logic [WIDTH*PW-1:0]        out_prs2,
  output logic [WIDTH*PW-1:0]        out_prd,
  output logic [WIDTH*PW-1:0]        out_old_prd,
  output logic [WIDTH-1:0]           out_rd_we,
  input  logic [RETIRE_WIDTH-1:0]    retire_valid,
  input  logic [RETIRE_WIDTH*PW-1:0] retire_preg,
  output logic [PW:0]                free_count
);

  lane_t         lanes [WIDTH];
  ren_lane_t     ren   [WIDTH];
  ren_lane_t     ren_p0 [WIDTH];
  logic          vld_p0;
  logic [WIDTH-1:0] alloc;
  logic [PW:0]   need;
  logic [PW:0]   count;
  logic [PW:0]   pop_cnt;
  logic [WIDTH*PW-1:0] peek;
  logic [PW-1:0] rat [ARCH_REGS];
  logic          accept;

  // Unpack the flat decoder buses into lane records.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      lanes[i].rs1   = AW_MAX'(in_rs1[i*AW +: AW]);
      lanes[i].rs2   = AW_MAX'(in_rs2[i*AW +: AW]);
      lanes[i].rd    = AW_MAX'(in_rd[i*AW +: AW]);
      lanes[i].rd_we = in_rd_we[i];
    end
  end

  // Allocate, look up sources and old mappings, bypassing earlier lanes of the group.
  always_comb begin
    int rank;
    rank = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ren[i]   = '0;
      alloc[i] = lanes[i].rd_we && (lanes[i].rd != '0);

      ren[i].prs1 = (lanes[i].rs1 == '0) ? PW_MAX'(P0) : PW_MAX'(rat[AW'(lanes[i].rs1)]);
      ren[i].prs2 = (lanes[i].rs2 == '0) ? PW_MAX'(P0) : PW_MAX'(rat[AW'(lanes[i].rs2)]);

      if (alloc[i]) begin
        ren[i].prd     = PW_MAX'(peek[rank*PW +: PW]);
        ren[i].old_prd = PW_MAX'(rat[AW'(lanes[i].rd)]);
        ren[i].rd_we   = 1'b1;
        rank = rank + 1;
      end

      // Later matching lanes overwrite earlier ones, so the highest j < i wins.
      for (int j = 0; j < i; j++) begin
        if (alloc[j] && (lanes[j].rd == lanes[i].rs1)) ren[i].prs1 = ren[j].prd;
        if (alloc[j] && (lanes[j].rd == lanes[i].rs2)) ren[i].prs2 = ren[j].prd;
        if (alloc[i] && alloc[j] && (lanes[j].rd == lanes[i].rd)) ren[i].old_prd = ren[j].prd;
      end
    end
    need = (PW+1)'(rank);
  end

  assign in_ready = rst_n && (!vld_p0 || out_ready) && (count >= need);
  assign accept   = in_valid && in_ready;
  assign pop_cnt  = accept ? need : '0;

  rename_freelist #(
    .DEPTH     (PHYS_REGS),
    .ARCH_REGS (ARCH_REGS),
    .POP_W     (WIDTH),
    .PUSH_W    (RETIRE_WIDTH)
  ) u_freelist (
    .clk        (clk),
    .rst_n      (rst_n),
    .pop_cnt    (pop_cnt),
    .peek       (peek),
    .push_valid (retire_valid),
    .push_preg  (retire_preg),
    .count      (count)
  );

  // RAT: identity after reset; accepted lanes update in order so WAW leaves the last lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < ARCH_REGS; k++) rat[k] <= PW'(k);
    end else if (accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (alloc[i]) rat[AW'(lanes[i].rd)] <= PW'(ren[i].prd);
      end
    end
  end

  // Output register: load on acceptance, hold under backpressure, drop once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      for (int i = 0; i < WIDTH; i++) ren_p0[i] <= '0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
      for (int i = 0; i < WIDTH; i++) ren_p0[i] <= ren[i];
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_valid  = vld_p0;
  assign free_count = count;

  for (genvar g = 0; g < WIDTH; g++) begin : g_out
    assign out_prs1[g*PW +: PW]    = PW'(ren_p0[g].prs1);
    assign out_prs2[g*PW +: PW]    = PW'(ren_p0[g].prs2);
    assign out_prd[g*PW +: PW]     = PW'(ren_p0[g].prd);
    assign out_old_prd[g*PW +: PW] = PW'(ren_p0[g].old_prd);
    assign out_rd_we[g]            = ren_p0[g].rd_we;
  end

endmodule

// File: tb/tb_rename_stage_n.sv
// Directed bench for rename_stage_n with hand-computed expectations.
module tb_rename_stage_n;

  localparam int WIDTH = 2;
  localparam int RW    = 2;
  localparam int AW    = 5;
  localparam int PW    = 6;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH*AW-1:0]  in_rs1;
  logic [WIDTH*AW-1:0]  in_rs2;
  logic [WIDTH*AW-1:0]  in_rd;
  logic [WIDTH-1:0]     in_rd_we;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH*PW-1:0]  out_prs1;
  logic [WIDTH*PW-1:0]  out_prs2;
  logic [WIDTH*PW-1:0]  out_prd;
  logic [WIDTH*PW-1:0]  out_old_prd;
  logic [WIDTH-1:0]     out_rd_we;
  logic [RW-1:0]        retire_valid;
  logic [RW*PW-1:0]     retire_preg;
  logic [PW:0]          free_count;

  int n_vec;
  int n_bad;

  rename_stage_n #(
    .WIDTH(WIDTH), .ARCH_REGS(32), .PHYS_REGS(64), .RETIRE_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_rd_we(out_rd_we),
    .retire_valid(retire_valid), .retire_preg(retire_preg),
    .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pl(input logic [WIDTH*PW-1:0] v, input int i);
    return 32'(v[i*PW +: PW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int rs1, input int rs2, input int rd, input bit we);
    in_rs1[i*AW +: AW] = AW'(rs1);
    in_rs2[i*AW +: AW] = AW'(rs2);
    in_rd[i*AW +: AW]  = AW'(rd);
    in_rd_we[i]        = we;
  endtask

  task automatic clr_in();
    in_valid = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = '0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    retire_valid = '0;
    retire_preg = '0;
    clr_in();

    // Reset with a group already presented: must not be accepted.
    set_lane(0, 1, 2, 5, 1'b1);
    set_lane(1, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_free", 32'(free_count), 32);
    chk("rst_prd", pl(out_prd, 0), 0);
    rst_n = 1'b1;
    #1;
    chk("a_ready", 32'(in_ready), 1);
    tick();
    chk("a_valid", 32'(out_valid), 1);
    chk("a_prs1", pl(out_prs1, 0), 1);
    chk("a_prs2", pl(out_prs2, 0), 2);
    chk("a_prd", pl(out_prd, 0), 32);
    chk("a_old", pl(out_old_prd, 0), 5);
    chk("a_we", 32'(out_rd_we), 1);
    chk("a_prd1", pl(out_prd, 1), 0);
    chk("a_free", 32'(free_count), 31);

    // Intra-group RAW and WAW on x3.
    set_lane(0, 5, 0, 3, 1'b1);
    set_lane(1, 3, 5, 3, 1'b1);
    #1;
    chk("b_ready", 32'(in_ready), 1);
    tick();
    chk("b_prs1_0", pl(out_prs1, 0), 32);
    chk("b_prd0", pl(out_prd, 0), 33);
    chk("b_old0", pl(out_old_prd, 0), 3);
    chk("b_prs1_1", pl(out_prs1, 1), 33);
    chk("b_prs2_1", pl(out_prs2, 1), 32);
    chk("b_prd1", pl(out_prd, 1), 34);
    chk("b_old1", pl(out_old_prd, 1), 33);
    chk("b_we", 32'(out_rd_we), 3);
    chk("b_free", 32'(free_count), 29);

    // No allocation: we=0 lane reading x3, and an rd=x0 lane with we=1.
    set_lane(0, 3, 0, 0, 1'b0);
    set_lane(1, 0, 0, 0, 1'b1);
    tick();
    chk("c_valid", 32'(out_valid), 1);
    chk("c_prs1", pl(out_prs1, 0), 34);
    chk("c_prs2", pl(out_prs2, 0), 0);
    chk("c_prd", 32'(out_prd), 0);
    chk("c_old", 32'(out_old_prd), 0);
    chk("c_we", 32'(out_rd_we), 0);
    chk("c_free", 32'(free_count), 29);

    // Drain the free list down to one entry.
    for (int g = 0; g < 14; g++) begin
      set_lane(0, 0, 0, 10, 1'b1);
      set_lane(1, 0, 0, 11, 1'b1);
      tick();
    end
    chk("d_prd0", pl(out_prd, 0), 61);
    chk("d_prd1", pl(out_prd, 1), 62);
    chk("d_old0", pl(out_old_prd, 0), 59);
    chk("d_old1", pl(out_old_prd, 1), 60);
    chk("d_free", 32'(free_count), 1);

    // Two-register group cannot fit in one free entry.
    set_lane(0, 0, 0, 12, 1'b1);
    set_lane(1, 0, 0, 13, 1'b1);
    #1;
    chk("e_stall_ready", 32'(in_ready), 0);
    tick();
    chk("e_stall_valid", 32'(out_valid), 0);
    chk("e_stall_free", 32'(free_count), 1);
    // Retire p7 in slot 0; slot 1 carries p0, which must be ignored.
    retire_valid = 2'b11;
    retire_preg  = {6'd0, 6'd7};
    #1;
    chk("e_ready_same_cyc", 32'(in_ready), 0);
    tick();
    retire_valid = '0;
    retire_preg  = '0;
    chk("e_free_after_ret", 32'(free_count), 2);
    chk("e_ready_after_ret", 32'(in_ready), 1);
    chk("e_no_accept", 32'(out_valid), 0);
    tick();
    chk("e_valid", 32'(out_valid), 1);
    chk("e_prd0", pl(out_prd, 0), 63);
    chk("e_prd1", pl(out_prd, 1), 7);
    chk("e_old0", pl(out_old_prd, 0), 12);
    chk("e_old1", pl(out_old_prd, 1), 13);
    chk("e_free", 32'(free_count), 0);
    clr_in();
    tick();
    chk("e_drain", 32'(out_valid), 0);

    // Return two superseded registers, then exercise backpressure.
    retire_valid = 2'b11;
    retire_preg  = {6'd33, 6'd3};
    tick();
    retire_valid = '0;
    retire_preg  = '0;
    chk("f_free_ret", 32'(free_count), 2);
    out_ready = 1'b0;
    set_lane(0, 10, 0, 14, 1'b1);
    set_lane(1, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("f_ready", 32'(in_ready), 1);
    tick();
    chk("f_valid", 32'(out_valid), 1);
    chk("f_prd", pl(out_prd, 0), 3);
    chk("f_old", pl(out_old_prd, 0), 14);
    chk("f_prs1", pl(out_prs1, 0), 61);
    set_lane(0, 0, 0, 15, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("f_bp_ready", 32'(in_ready), 0);
      tick();
      chk("f_bp_valid", 32'(out_valid), 1);
      chk("f_bp_prd", pl(out_prd, 0), 3);
      chk("f_bp_old", pl(out_old_prd, 0), 14);
      chk("f_bp_free", 32'(free_count), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("f_release_ready", 32'(in_ready), 1);
    tick();
    chk("g_valid", 32'(out_valid), 1);
    chk("g_prd", pl(out_prd, 0), 33);
    chk("g_old", pl(out_old_prd, 0), 15);
    chk("g_free", 32'(free_count), 0);

    // Reset while a group is held at the output.
    clr_in();
    rst_n = 1'b0;
    tick();
    chk("h_valid", 32'(out_valid), 0);
    chk("h_free", 32'(free_count), 32);
    chk("h_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    set_lane(0, 5, 10, 5, 1'b1);
    set_lane(1, 3, 0, 0, 1'b0);
    in_valid = 1'b1;
    tick();
    chk("h_prs1", pl(out_prs1, 0), 5);
    chk("h_prs2", pl(out_prs2, 0), 10);
    chk("h_prd", pl(out_prd, 0), 32);
    chk("h_old", pl(out_old_prd, 0), 5);
    chk("h_prs1_1", pl(out_prs1, 1), 3);
    chk("h_free", 32'(free_count), 31);
    clr_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
